nonce_event_queue: RTL and testbench

//  Collects found-nonce strobes from the LOCAL_MINERS hashing cores.

---
 rtl/nonce_event_queue_if.sv | 29 ++
 rtl/nonce_event_queue.sv | 173 +++++++++++++++++
 tb/tb_nonce_event_queue.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nonce_event_queue_if.sv
// Found-nonce collection bus: per-miner strobes in, queued result stream plus
// share LED trigger and statistics out.
interface nonce_event_queue_if #(
    parameter int LOCAL_MINERS = 5,
    parameter int NONCE_BITS   = 32,
    parameter int COUNT_BITS   = 16
);
    localparam int ID_BITS = (LOCAL_MINERS > 1) ? $clog2(LOCAL_MINERS) : 1;

    logic [LOCAL_MINERS-1:0]            miner_valid;
    logic [LOCAL_MINERS*NONCE_BITS-1:0] miner_nonce;
    logic                               out_valid;
    logic                               out_ready;
    logic [NONCE_BITS-1:0]              out_nonce;
    logic [ID_BITS-1:0]                 out_miner_id;
    logic                               trigger;
    logic [COUNT_BITS-1:0]              share_count;
    logic                               overflow;

    modport master (
        input  miner_valid, miner_nonce, out_ready,
        output out_valid, out_nonce, out_miner_id, trigger, share_count, overflow
    );

    modport slave (
        output miner_valid, miner_nonce, out_ready,
        input  out_valid, out_nonce, out_miner_id, trigger, share_count, overflow
    );
endinterface

// File: rtl/nonce_event_queue.sv
// Per-miner pending registers -> round-robin arbiter -> FWFT FIFO of found nonces.
// Optional feature macro TRIGGER_HOLDOFF_EN: suppress LED triggers during a holdoff window.
module nonce_event_queue #(
    parameter int LOCAL_MINERS = 5,
    parameter int NONCE_BITS   = 32,
    parameter int FIFO_AW      = 2,
    parameter int COUNT_BITS   = 16
`ifdef TRIGGER_HOLDOFF_EN
    ,
    parameter int HOLDOFF_BITS = 24
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    nonce_event_queue_if.master bus
);
    localparam int ID_BITS = (LOCAL_MINERS > 1) ? $clog2(LOCAL_MINERS) : 1;
    localparam int DEPTH   = 1 << FIFO_AW;
    localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;

    logic [LOCAL_MINERS-1:0] pend_r;
    logic [NONCE_BITS-1:0]   pend_nonce_r [LOCAL_MINERS];
    logic [ID_BITS-1:0]      rr_ptr_r;
    logic [NONCE_BITS-1:0]   fifo_nonce_r [DEPTH];
    logic [ID_BITS-1:0]      fifo_id_r [DEPTH];
    logic [FIFO_AW:0]        wr_ptr_r;
    logic [FIFO_AW:0]        rd_ptr_r;
    logic                    trigger_r;
    logic                    overflow_r;
    logic [COUNT_BITS-1:0]   share_count_r;

    logic                    empty_s;
    logic                    full_s;
    logic                    pop_s;
    logic                    push_ok_s;
    logic                    push_s;
    logic                    hit_hi_s;
    logic                    hit_lo_s;
    logic [ID_BITS-1:0]      win_hi_s;
    logic [ID_BITS-1:0]      win_lo_s;
    logic [ID_BITS-1:0]      win_s;
    logic [ID_BITS-1:0]      rr_next_s;
    logic [LOCAL_MINERS-1:0] gnt_vec_s;
    logic                    drop_s;

    // FIFO occupancy and handshake qualification
    always_comb begin
        empty_s   = (wr_ptr_r == rd_ptr_r);
        full_s    = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                    (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
        pop_s     = !empty_s && bus.out_ready;
        push_ok_s = !full_s || pop_s;
    end

    // Round-robin pick: lowest pending index at/after rr_ptr, else lowest overall (wrap)
    always_comb begin
        hit_hi_s = 1'b0;
        hit_lo_s = 1'b0;
        win_hi_s = '0;
        win_lo_s = '0;
        for (int i = LOCAL_MINERS - 1; i >= 0; i--) begin
            win_hi_s = (pend_r[i] && (i >= int'(rr_ptr_r))) ? ID_BITS'(i) : win_hi_s;
            hit_hi_s = hit_hi_s || (pend_r[i] && (i >= int'(rr_ptr_r)));
            win_lo_s = pend_r[i] ? ID_BITS'(i) : win_lo_s;
            hit_lo_s = hit_lo_s || pend_r[i];
        end
        win_s     = hit_hi_s ? win_hi_s : win_lo_s;
        push_s    = push_ok_s && hit_lo_s;
        rr_next_s = (win_s == ID_BITS'(LOCAL_MINERS - 1)) ? '0 : win_s + ID_BITS'(1);
        for (int i = 0; i < LOCAL_MINERS; i++) begin
            gnt_vec_s[i] = push_s && (win_s == ID_BITS'(i));
        end
        drop_s = |(bus.miner_valid & pend_r & ~gnt_vec_s);
    end

    // Pending capture: a winner's slot is freed in the same cycle, so a new strobe refills it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r <= '0;
            for (int i = 0; i < LOCAL_MINERS; i++) begin
                pend_nonce_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < LOCAL_MINERS; i++) begin
                if (bus.miner_valid[i] && (!pend_r[i] || gnt_vec_s[i])) begin
                    pend_r[i]       <= 1'b1;
                    pend_nonce_r[i] <= bus.miner_nonce[i*NONCE_BITS +: NONCE_BITS];
                end else if (gnt_vec_s[i]) begin
                    pend_r[i] <= 1'b0;
                end
            end
        end
    end

    // Arbiter fairness pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_r <= '0;
        end else if (push_s) begin
            rr_ptr_r <= rr_next_s;
        end
    end

    // FIFO storage; contents cleared so the head reads zero out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_nonce_r[i] <= '0;
                fifo_id_r[i]    <= '0;
            end
        end else begin
            if (push_s) begin
                fifo_nonce_r[wr_ptr_r[FIFO_AW-1:0]] <= pend_nonce_r[win_s];
                fifo_id_r[wr_ptr_r[FIFO_AW-1:0]]    <= win_s;
                wr_ptr_r                            <= wr_ptr_r + (FIFO_AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (FIFO_AW+1)'(1);
            end
        end
    end

`ifdef TRIGGER_HOLDOFF_EN
    logic [HOLDOFF_BITS-1:0] holdoff_r;

    // LED trigger, rate-limited by a down-counter reloaded on every pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trigger_r <= 1'b0;
            holdoff_r <= '0;
        end else if (push_s && (holdoff_r == '0)) begin
            trigger_r <= 1'b1;
            holdoff_r <= '1;
        end else begin
            trigger_r <= 1'b0;
            if (holdoff_r != '0) begin
                holdoff_r <= holdoff_r - HOLDOFF_BITS'(1);
            end
        end
    end
`else
    // LED trigger: one pulse per push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trigger_r <= 1'b0;
        end else begin
            trigger_r <= push_s;
        end
    end
`endif

    // Saturating share counter and sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            share_count_r <= '0;
            overflow_r    <= 1'b0;
        end else begin
            if (push_s && (share_count_r != COUNT_MAX)) begin
                share_count_r <= share_count_r + COUNT_BITS'(1);
            end
            overflow_r <= overflow_r | drop_s;
        end
    end

    assign bus.out_valid    = !empty_s;
    assign bus.out_nonce    = fifo_nonce_r[rd_ptr_r[FIFO_AW-1:0]];
    assign bus.out_miner_id = fifo_id_r[rd_ptr_r[FIFO_AW-1:0]];
    assign bus.trigger      = trigger_r;
    assign bus.share_count  = share_count_r;
    assign bus.overflow     = overflow_r;
endmodule

// File: tb/tb_nonce_event_queue.sv
// Bench for nonce_event_queue: directed vector table, corner sequences, then
// randomized traffic against a queue-based reference model.
module tb_nonce_event_queue;
    localparam int LM    = 5;
    localparam int NB    = 32;
    localparam int AW    = 2;
    localparam int CB    = 16;
    localparam int IDB   = 3;
    localparam int DEPTH = 4;
    localparam int HB    = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nonce_event_queue_if #(.LOCAL_MINERS(LM), .NONCE_BITS(NB), .COUNT_BITS(CB)) bus ();

`ifdef TRIGGER_HOLDOFF_EN
    nonce_event_queue #(.LOCAL_MINERS(LM), .NONCE_BITS(NB), .FIFO_AW(AW), .COUNT_BITS(CB),
                        .HOLDOFF_BITS(HB)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    nonce_event_queue #(.LOCAL_MINERS(LM), .NONCE_BITS(NB), .FIFO_AW(AW), .COUNT_BITS(CB))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    typedef struct packed { logic [IDB-1:0] id; logic [NB-1:0] nonce; } ent_t;
    ent_t            m_q[$];
    bit              m_pend [LM];
    logic [NB-1:0]   m_pn   [LM];
    int              m_rr;
    bit              m_trig;
    int              m_cnt;
    bit              m_ovf;
    int              m_hold;
    logic [NB-1:0]   nin    [LM];

    typedef struct {
        bit            rst;
        logic [LM-1:0] mv;
        logic [NB-1:0] nonce;
        bit            rdy;
        bit            v;
        logic [IDB-1:0] id;
        logic [NB-1:0] en;
        bit            t;
        int            cnt;
        bit            ovf;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < LM; i++) begin
            m_pend[i] = 1'b0;
            m_pn[i]   = '0;
        end
        m_rr   = 0;
        m_trig = 1'b0;
        m_cnt  = 0;
        m_ovf  = 1'b0;
        m_hold = 0;
    endtask

    task automatic model_step(input logic [LM-1:0] mv, input bit rdy);
        bit   pop;
        bit   ok;
        bit   g;
        int   w;
        ent_t e;
        pop = (m_q.size() > 0) && rdy;
        ok  = (m_q.size() < DEPTH) || pop;
        g   = 1'b0;
        w   = 0;
        for (int k = 0; k < LM; k++) begin
            int idx;
            idx = (m_rr + k) % LM;
            if (!g && m_pend[idx]) begin
                g = 1'b1;
                w = idx;
            end
        end
        g = g && ok;
        if (pop) void'(m_q.pop_front());
        if (g) begin
            e.id    = IDB'(w);
            e.nonce = m_pn[w];
            m_q.push_back(e);
            m_pend[w] = 1'b0;
            m_rr      = (w + 1) % LM;
        end
        for (int i = 0; i < LM; i++) begin
            if (mv[i]) begin
                if (m_pend[i]) m_ovf = 1'b1;
                else begin
                    m_pend[i] = 1'b1;
                    m_pn[i]   = nin[i];
                end
            end
        end
`ifdef TRIGGER_HOLDOFF_EN
        if (g && m_hold == 0) begin
            m_trig = 1'b1;
            m_hold = (1 << HB) - 1;
        end else begin
            m_trig = 1'b0;
            if (m_hold > 0) m_hold--;
        end
`else
        m_trig = g;
`endif
        if (g && m_cnt < (1 << CB) - 1) m_cnt++;
    endtask

    task automatic tick(input logic [LM-1:0] mv, input bit rdy);
        for (int i = 0; i < LM; i++) bus.miner_nonce[i*NB +: NB] = nin[i];
        bus.miner_valid = mv;
        bus.out_ready   = rdy;
        @(posedge clk);
        model_step(mv, rdy);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk({tag, "_nonce"}, 64'(bus.out_nonce), 64'(m_q[0].nonce));
            chk({tag, "_id"}, 64'(bus.out_miner_id), 64'(m_q[0].id));
        end
        chk({tag, "_trigger"}, 64'(bus.trigger), 64'(m_trig));
        chk({tag, "_count"}, 64'(bus.share_count), 64'(m_cnt));
        chk({tag, "_overflow"}, 64'(bus.overflow), 64'(m_ovf));
    endtask

    task automatic add(input bit rst, input logic [LM-1:0] mv, input logic [NB-1:0] nonce,
                       input bit rdy, input bit v, input logic [IDB-1:0] id,
                       input logic [NB-1:0] en, input bit t, input int cnt, input bit ovf);
        vec_t r;
        r.rst = rst; r.mv = mv; r.nonce = nonce; r.rdy = rdy; r.v = v;
        r.id = id; r.en = en; r.t = t; r.cnt = cnt; r.ovf = ovf;
        tbl.push_back(r);
    endtask

    initial begin
        int trig_seen;
        string tag;
        rst_n           = 1'b1;
        bus.miner_valid = '0;
        bus.miner_nonce = '0;
        bus.out_ready   = 1'b0;
        for (int i = 0; i < LM; i++) nin[i] = '0;
        model_reset();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_trigger", 64'(bus.trigger), 64'd0);
        chk("reset_count", 64'(bus.share_count), 64'd0);
        chk("reset_overflow", 64'(bus.overflow), 64'd0);
        chk("reset_nonce", 64'(bus.out_nonce), 64'd0);

        // single strobe: visible two cycles later
        add(1'b1, 5'b00000, 32'h0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 0, 1'b0);
        for (int c = 0; c < 9; c++) add(1'b0, 5'b00000, 32'h0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 0, 1'b0);
        add(1'b0, 5'b00100, 32'hDEADBEEF, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 0, 1'b0);
        add(1'b0, 5'b00000, 32'h0, 1'b1, 1'b1, 3'd2, 32'hDEADBEEF, 1'b1, 1, 1'b0);
        add(1'b0, 5'b00000, 32'h0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 1, 1'b0);
        // all five at once, consumer stalled: four queue, miner 4 waits
        add(1'b1, 5'b00000, 32'h0, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 0, 1'b0);
        add(1'b0, 5'b11111, 32'h12345678, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 0, 1'b0);
        for (int c = 1; c <= 4; c++) add(1'b0, 5'b00000, 32'h0, 1'b0, 1'b1, 3'd0, 32'h12345678, 1'b1, c, 1'b0);
        add(1'b0, 5'b00000, 32'h0, 1'b0, 1'b1, 3'd0, 32'h12345678, 1'b0, 4, 1'b0);
        add(1'b0, 5'b00000, 32'h0, 1'b1, 1'b1, 3'd1, 32'h12345678, 1'b1, 5, 1'b0);
        for (int c = 2; c <= 4; c++) add(1'b0, 5'b00000, 32'h0, 1'b1, 1'b1, IDB'(c), 32'h12345678, 1'b0, 5, 1'b0);
        add(1'b0, 5'b00000, 32'h0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 5, 1'b0);
        // full FIFO, miner 1 strobes twice: second nonce dropped
        add(1'b0, 5'b01111, 32'hA0000001, 1'b0, 1'b0, 3'd0, 32'h0, 1'b0, 5, 1'b0);
        for (int c = 6; c <= 9; c++) add(1'b0, 5'b00000, 32'h0, 1'b0, 1'b1, 3'd0, 32'hA0000001, 1'b1, c, 1'b0);
        add(1'b0, 5'b00010, 32'hB1B1B1B1, 1'b0, 1'b1, 3'd0, 32'hA0000001, 1'b0, 9, 1'b0);
        add(1'b0, 5'b00000, 32'h0, 1'b0, 1'b1, 3'd0, 32'hA0000001, 1'b0, 9, 1'b0);
        add(1'b0, 5'b00010, 32'hB2B2B2B2, 1'b0, 1'b1, 3'd0, 32'hA0000001, 1'b0, 9, 1'b1);
        add(1'b0, 5'b00000, 32'h0, 1'b1, 1'b1, 3'd1, 32'hA0000001, 1'b1, 10, 1'b1);
        add(1'b0, 5'b00000, 32'h0, 1'b1, 1'b1, 3'd2, 32'hA0000001, 1'b0, 10, 1'b1);
        add(1'b0, 5'b00000, 32'h0, 1'b1, 1'b1, 3'd3, 32'hA0000001, 1'b0, 10, 1'b1);
        add(1'b0, 5'b00000, 32'h0, 1'b1, 1'b1, 3'd1, 32'hB1B1B1B1, 1'b0, 10, 1'b1);
        add(1'b0, 5'b00000, 32'h0, 1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 10, 1'b1);

        foreach (tbl[r]) begin
            for (int i = 0; i < LM; i++) nin[i] = tbl[r].nonce;
            if (tbl[r].rst) rst_n = 1'b0;
            tick(tbl[r].mv, tbl[r].rdy);
            if (tbl[r].rst) model_reset();
            tag = $sformatf("row%0d", r);
            chk({tag, "_valid"}, 64'(bus.out_valid), 64'(tbl[r].v));
            if (tbl[r].v) begin
                chk({tag, "_nonce"}, 64'(bus.out_nonce), 64'(tbl[r].en));
                chk({tag, "_id"}, 64'(bus.out_miner_id), 64'(tbl[r].id));
            end
`ifndef TRIGGER_HOLDOFF_EN
            chk({tag, "_trigger"}, 64'(bus.trigger), 64'(tbl[r].t));
`endif
            chk({tag, "_count"}, 64'(bus.share_count), 64'(tbl[r].cnt));
            chk({tag, "_overflow"}, 64'(bus.overflow), 64'(tbl[r].ovf));
            check_model({tag, "_model"});
            rst_n = 1'b1;
        end

        // full FIFO draining while a pending nonce refills every cycle
        for (int i = 0; i < LM; i++) nin[i] = $urandom;
        tick(5'b11111, 1'b0);
        check_model("t4_fill");
        for (int c = 0; c < 4; c++) begin
            tick(5'b00000, 1'b0);
            check_model("t4_fill");
        end
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < LM; i++) nin[i] = $urandom;
            tick(5'b11111, 1'b1);
            check_model("t4_stream");
`ifndef TRIGGER_HOLDOFF_EN
            chk("t4_trigger", 64'(bus.trigger), 64'd1);
`endif
            chk("t4_valid", 64'(bus.out_valid), 64'd1);
        end

        // asynchronous reset with three entries queued
        for (int c = 0; c < 10; c++) begin
            tick(5'b00000, 1'b1);
            check_model("t5_drain");
        end
        for (int i = 0; i < LM; i++) nin[i] = $urandom;
        tick(5'b10101, 1'b0);
        check_model("t5_load");
        for (int c = 0; c < 3; c++) begin
            tick(5'b00000, 1'b0);
            check_model("t5_load");
        end
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t5_rst_trigger", 64'(bus.trigger), 64'd0);
        chk("t5_rst_count", 64'(bus.share_count), 64'd0);
        chk("t5_rst_overflow", 64'(bus.overflow), 64'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick(5'b00000, 1'b1);
            check_model("t5_after");
        end

`ifdef TRIGGER_HOLDOFF_EN
        rst_n = 1'b0;
        tick(5'b00000, 1'b1);
        model_reset();
        rst_n = 1'b1;
        trig_seen = 0;
        for (int c = 0; c < 25; c++) begin
            nin[0] = $urandom;
            tick((c == 0 || c == 5 || c == 20) ? 5'b00001 : 5'b00000, 1'b1);
            check_model("t6");
            trig_seen += int'(bus.trigger);
        end
        chk("t6_triggers", 64'(trig_seen), 64'd2);
        chk("t6_count", 64'(bus.share_count), 64'd3);
`endif

        // randomized traffic, alternating light and heavy back-pressure
        for (int c = 0; c < 3000; c++) begin
            logic [LM-1:0] mv;
            bit rdy;
            for (int i = 0; i < LM; i++) nin[i] = $urandom;
            mv  = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
            rdy = ((c / 300) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick(mv, rdy);
            check_model("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
